// File: rtl/ibuf2mac_pkg.sv
// Shared definitions for the ibuf-to-MAC drain stage: FSM encoding, header
// field position and the beat payload carried through the skid buffer.
package ibuf2mac_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned NQ_W    = LEN_W - 2;
  localparam int unsigned QW_W    = 64;
  localparam int unsigned STRB_W  = QW_W / 8;

  typedef struct packed {
    logic [QW_W-1:0]   data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } beat_t;

  // Number of payload QWs following a header of the given byte length.
  function automatic logic [NQ_W-1:0] len2nq(input logic [LEN_W-1:0] len);
    return NQ_W'((32'(len) + 32'd7) >> 3);
  endfunction

  // Byte enables of the final beat of a frame.
  function automatic logic [STRB_W-1:0] last_strb(input logic [LEN_W-1:0] len);
    return (len[2:0] == 3'd0) ? {STRB_W{1'b1}}
                              : STRB_W'((9'd1 << len[2:0]) - 9'd1);
  endfunction

endpackage

// File: rtl/ibuf2mac_skid.sv
// Two-entry beat FIFO between the BRAM read pipeline and the AXI-stream port;
// the head entry drives the stream outputs directly from registers.
module ibuf2mac_skid
  import ibuf2mac_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  beat_t din,
  input  logic  ready,
  output beat_t dout,
  output logic  dout_vld,
  output logic  full,
  output logic  afull
);

  beat_t tail_q;
  logic  tail_vld_q;
  logic  pop_c;

  assign pop_c = dout_vld & ready;
  assign full  = tail_vld_q;
  assign afull = dout_vld & ~tail_vld_q;

  // The issuer never pushes into a full buffer unless the head is leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_vld   <= 1'b0;
      tail_q     <= '0;
      tail_vld_q <= 1'b0;
    end else if (pop_c) begin
      if (tail_vld_q) begin
        dout <= tail_q;
        if (push) tail_q <= din;
        else      tail_vld_q <= 1'b0;
      end else if (push) begin
        dout <= din;
      end else begin
        dout_vld <= 1'b0;
      end
    end else if (push) begin
      if (!dout_vld) begin
        dout     <= din;
        dout_vld <= 1'b1;
      end else begin
        tail_q     <= din;
        tail_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibuf2mac.sv
// Store-and-forward drain of length-prefixed frames from the ibuf BRAM to the
// 10G MAC TX stream; frees ibuf space only when a frame has fully left.
module ibuf2mac
  import ibuf2mac_pkg::*;
#(
  parameter int unsigned BW      = 9,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BW:0]       committed_prod,
  output logic [BW:0]       committed_cons,
  output logic [BW-1:0]     rd_addr,
  input  logic [QW_W-1:0]   rd_data,
  output logic [QW_W-1:0]   m_axis_tdata,
  output logic [STRB_W-1:0] m_axis_tstrb,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [31:0]       drop_cnt
);

  localparam int unsigned PW = BW + 1;

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    cons_q, cons_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [NQ_W-1:0]  nq_q, nq_d, iss_q, iss_d;
  logic             drop_q, drop_d;
  logic [31:0]      drop_cnt_q, drop_cnt_d;
  logic             rd_vld_q, rd_last_q;

  logic [PW-1:0]    avail_c;
  logic [LEN_W-1:0] hdr_len_c;
  logic             avail_ok_c, pop_c, room_c, last_iss_c, issue_c;
  logic [2:0]       lvl_c;
  logic             skid_full, skid_afull;
  beat_t            skid_in, skid_out;

  assign hdr_len_c  = rd_data[LEN_LSB +: LEN_W];
  assign avail_c    = committed_prod - cons_q;
  assign avail_ok_c = 32'(avail_c) >= (32'(nq_q) + 32'd1);
  assign pop_c      = m_axis_tvalid & m_axis_tready;
  assign last_iss_c = (iss_q == (nq_q - NQ_W'(1)));

  // Skid occupancy after this cycle, including the read already in flight.
  assign lvl_c  = {1'b0, skid_full, skid_afull};
  assign room_c = ((lvl_c + 3'(rd_vld_q)) - 3'(pop_c)) <= 3'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // The first payload read is launched from S_WAIT so the first beat is not
  // delayed by an extra address cycle.
  always_comb begin
    state_d    = state_q;
    cons_d     = cons_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    nq_d       = nq_q;
    iss_d      = iss_q;
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    issue_c    = 1'b0;
    case (state_q)
      S_IDLE: if (avail_c != '0) state_d = S_HDR;
      S_HDR: begin
        len_d    = hdr_len_c;
        nq_d     = len2nq(hdr_len_c);
        iss_d    = '0;
        rd_ptr_d = cons_q + PW'(1);
        if (hdr_len_c == '0) begin
          cons_d  = cons_q + PW'(1);
          state_d = S_IDLE;
        end else begin
          drop_d  = (32'(hdr_len_c) < MIN_LEN) || (32'(hdr_len_c) > MAX_LEN);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (avail_ok_c) begin
          if (drop_q) begin
            cons_d   = cons_q + PW'(nq_q) + PW'(1);
            rd_ptr_d = cons_q + PW'(nq_q) + PW'(1);
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
            state_d  = S_IDLE;
          end else begin
            issue_c = 1'b1;
            state_d = last_iss_c ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (room_c) begin
          issue_c = 1'b1;
          if (last_iss_c) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (pop_c && m_axis_tlast) begin
          cons_d   = cons_q + PW'(nq_q) + PW'(1);
          rd_ptr_d = cons_q + PW'(nq_q) + PW'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      iss_d    = iss_q + NQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cons_q     <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      nq_q       <= '0;
      iss_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      cons_q     <= cons_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      nq_q       <= nq_d;
      iss_q      <= iss_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
      rd_vld_q   <= issue_c;
      rd_last_q  <= issue_c & last_iss_c;
    end
  end

  always_comb begin
    skid_in.data = rd_data;
    skid_in.strb = rd_last_q ? last_strb(len_q) : {STRB_W{1'b1}};
    skid_in.last = rd_last_q;
  end

  ibuf2mac_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_vld_q),
    .din      (skid_in),
    .ready    (m_axis_tready),
    .dout     (skid_out),
    .dout_vld (m_axis_tvalid),
    .full     (skid_full),
    .afull    (skid_afull)
  );

  assign m_axis_tdata   = skid_out.data;
  assign m_axis_tstrb   = skid_out.strb;
  assign m_axis_tlast   = skid_out.last;
  assign committed_cons = cons_q;
  assign rd_addr        = rd_ptr_q[BW-1:0];
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_ibuf2mac.sv
// Directed bench for ibuf2mac: BRAM model, frame writer and a stream receiver
// that checks beat content, ordering and stability under stalls.
module tb_ibuf2mac;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  committed_prod;
  logic [9:0]  committed_cons;
  logic [8:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [512];

  always #5 clk = ~clk;

  always_ff @(posedge clk) rd_data <= mem[rd_addr];

  ibuf2mac #(.BW(9), .MAX_LEN(1518), .MIN_LEN(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .committed_prod (committed_prod),
    .committed_cons (committed_cons),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .drop_cnt       (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int fid, input int k);
    return {16'hC0DE, 16'(fid), (32'(k) * 32'h0001_0003) + 32'h00A5_5A00};
  endfunction

  task automatic write_frame(input int hdr, input int len, input int fid);
    mem[9'(hdr % 512)] = 64'hDEAD_BEEF_0000_0000 | 64'(len);
    for (int k = 0; k < (len + 7) / 8; k++) mem[9'((hdr + 1 + k) % 512)] = pat(fid, k);
  endtask

  task automatic recv(input int fid, input int n, input logic [7:0] lstrb, input bit bp,
                      output int cyc, output logic [9:0] cons_at_last);
    int beats, t, first;
    bit stalled, done;
    logic [63:0] held_d;
    logic [8:0]  held_c;
    beats = 0; t = 0; first = -1; stalled = 0; done = 0; cyc = 0;
    cons_at_last = '0; held_d = '0; held_c = '0;
    while (!done && t < 4000) begin
      @(negedge clk);
      t++;
      if (stalled) begin
        chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_data", m_axis_tdata, held_d);
        chk("stall_ctl", 64'({m_axis_tstrb, m_axis_tlast}), 64'(held_c));
      end
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          if (first < 0) first = t;
          chk("beat_data", m_axis_tdata, pat(fid, beats));
          chk("beat_strb", 64'(m_axis_tstrb), 64'((beats == n - 1) ? lstrb : 8'hFF));
          chk("beat_last", 64'(m_axis_tlast), 64'(beats == n - 1));
          beats++;
          if (m_axis_tlast) begin
            done = 1;
            cyc = t - first + 1;
            cons_at_last = committed_cons;
          end
        end else begin
          stalled = 1;
          held_d = m_axis_tdata;
          held_c = {m_axis_tstrb, m_axis_tlast};
        end
      end
    end
    chk("recv_done", 64'(done), 64'd1);
    chk("beat_count", 64'(beats), 64'(n));
    m_axis_tready = 1'b1;
  endtask

  int cyc;
  logic [9:0] cons_last;
  bit saw_valid;
  int t;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    rst = 1'b1;
    committed_prod = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cons", 64'(committed_cons), 64'd0);
    chk("rst_addr", 64'(rd_addr), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_ctl", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb}), 64'd0);
    chk("rst_data", m_axis_tdata, 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;

    // 64-byte frame at address 0
    write_frame(0, 64, 1);
    committed_prod = 10'd9;
    recv(1, 8, 8'hFF, 0, cyc, cons_last);
    chk("f64_rate", 64'(cyc), 64'd8);
    chk("f64_cons_mid", 64'(cons_last), 64'd0);
    @(negedge clk);
    chk("f64_cons", 64'(committed_cons), 64'd9);

    // 61-byte frame, partial last beat
    write_frame(9, 61, 2);
    committed_prod = 10'd18;
    recv(2, 8, 8'h1F, 0, cyc, cons_last);
    chk("f61_rate", 64'(cyc), 64'd8);
    @(negedge clk);
    chk("f61_cons", 64'(committed_cons), 64'd18);

    // 1514-byte frame with random backpressure
    write_frame(18, 1514, 3);
    committed_prod = 10'd209;
    recv(3, 190, 8'h03, 1, cyc, cons_last);
    @(negedge clk);
    chk("f1514_cons", 64'(committed_cons), 64'd209);

    // Oversized frame is dropped
    mem[209] = 64'(2000);
    committed_prod = 10'd460;
    saw_valid = 0;
    t = 0;
    while (committed_cons != 10'd460 && t < 200) begin
      @(negedge clk);
      t++;
      saw_valid |= m_axis_tvalid;
    end
    chk("drop_cons", 64'(committed_cons), 64'd460);
    chk("drop_novalid", 64'(saw_valid), 64'd0);
    chk("drop_cnt", 64'(drop_cnt), 64'd1);

    // Store-and-forward: partially committed frame must not start
    write_frame(460, 64, 5);
    committed_prod = 10'd465;
    saw_valid = 0;
    repeat (30) begin
      @(negedge clk);
      saw_valid |= m_axis_tvalid;
    end
    chk("saf_novalid", 64'(saw_valid), 64'd0);
    chk("saf_cons_hold", 64'(committed_cons), 64'd460);
    committed_prod = 10'd469;
    recv(5, 8, 8'hFF, 0, cyc, cons_last);
    @(negedge clk);
    chk("saf_cons", 64'(committed_cons), 64'd469);

    // Padding QWs up to the wrap point
    for (int a = 469; a < 510; a++) mem[a] = '0;
    committed_prod = 10'd510;
    saw_valid = 0;
    t = 0;
    while (committed_cons != 10'd510 && t < 300) begin
      @(negedge clk);
      t++;
      saw_valid |= m_axis_tvalid;
    end
    chk("pad_cons", 64'(committed_cons), 64'd510);
    chk("pad_novalid", 64'(saw_valid), 64'd0);
    chk("pad_drop", 64'(drop_cnt), 64'd1);

    // Frame straddling the end of the ibuf
    write_frame(510, 40, 7);
    committed_prod = 10'd516;
    recv(7, 5, 8'hFF, 0, cyc, cons_last);
    chk("wrap_rate", 64'(cyc), 64'd5);
    @(negedge clk);
    chk("wrap_cons", 64'(committed_cons), 64'd516);

    // Reset in the middle of a stalled frame
    write_frame(516, 64, 8);
    m_axis_tready = 1'b0;
    committed_prod = 10'd525;
    t = 0;
    while (!m_axis_tvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mid_valid", 64'(m_axis_tvalid), 64'd1);
    rst = 1'b1;
    committed_prod = '0;
    @(negedge clk);
    chk("mid_rst_cons", 64'(committed_cons), 64'd0);
    chk("mid_rst_addr", 64'(rd_addr), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_ctl", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb}), 64'd0);
    chk("mid_rst_data", m_axis_tdata, 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    saw_valid = 0;
    repeat (10) begin
      @(negedge clk);
      saw_valid |= m_axis_tvalid;
    end
    chk("post_rst_idle", 64'(saw_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
